// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin arbiter that time-shares a 4:1 one-bit mux among four
//            requesters. Define MUX_ARB_TIMEOUT_EN to add MAX_HOLD pre-emption.
// Revision : 1.0
// =============================================================================
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       in0,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [3:0] grant,
    output logic       address0,
    output logic       address1,
    output logic       valid,
    output logic       out
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [1:0] r_addr;
    logic [1:0] w_addr_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;

    logic [2:0] w_pick;
    logic [2:0] w_repick;
    logic [3:0] w_others;
    logic [1:0] w_owner_inc;
    logic       w_release;
    logic       w_sel;

    // Returns {found, index} of the first set bit scanning circularly from start.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign w_owner_inc = r_owner + 2'd1;
    assign w_pick      = rr_pick(req, r_ptr);
    // r_grant is the owner's one-hot while busy, so this masks the owner out.
    assign w_others    = req & ~r_grant;
    assign w_repick    = rr_pick(w_others, w_owner_inc);

`ifdef MUX_ARB_TIMEOUT_EN
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;
    logic       w_timeout;

    assign w_timeout = (r_hold == c_max_hold) && (w_others != 4'b0000);
    assign w_release = !req[r_owner] || w_timeout;
`else
    logic w_unused_max_hold;

    assign w_unused_max_hold = ^c_max_hold;
    assign w_release         = !req[r_owner];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_addr_nxt  = r_addr;
        w_grant_nxt = r_grant;
`ifdef MUX_ARB_TIMEOUT_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick[2]) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_pick[1:0];
                    w_addr_nxt  = w_pick[1:0];
                    w_grant_nxt = onehot(w_pick[1:0]);
`ifdef MUX_ARB_TIMEOUT_EN
                    w_hold_nxt  = 4'd1;
`endif
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt = w_owner_inc;
                    if (w_repick[2]) begin
                        w_owner_nxt = w_repick[1:0];
                        w_addr_nxt  = w_repick[1:0];
                        w_grant_nxt = onehot(w_repick[1:0]);
`ifdef MUX_ARB_TIMEOUT_EN
                        w_hold_nxt  = 4'd1;
`endif
                    end else begin
                        // Address deliberately keeps its last value when idle.
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    if (r_hold != 4'd15) begin
                        w_hold_nxt = r_hold + 4'd1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_owner <= 2'd0;
            r_addr  <= 2'd0;
            r_grant <= 4'b0000;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hold  <= 4'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_addr  <= w_addr_nxt;
            r_grant <= w_grant_nxt;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_sel = 1'b0;
        case (r_addr)
            2'd0:    w_sel = in0;
            2'd1:    w_sel = in1;
            2'd2:    w_sel = in2;
            default: w_sel = in3;
        endcase
    end

    assign grant    = r_grant;
    assign address0 = r_addr[0];
    assign address1 = r_addr[1];
    assign valid    = (r_state == ST_BUSY);
    assign out      = valid & w_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Directed plus random checks of mux_rr_arbiter against a queue-free
//            round-robin reference model. Revision : 1.0
// =============================================================================
module tb_mux_rr_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] grant;
    logic       address0;
    logic       address1;
    logic       valid;
    logic       out;

    int n_cmp;
    int n_err;

    // Reference model state, held as plain integers.
    int m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_addr;

    mux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .in0      (din[0]),
        .in1      (din[1]),
        .in2      (din[2]),
        .in3      (din[3]),
        .grant    (grant),
        .address0 (address0),
        .address1 (address1),
        .valid    (valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int scan(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rs);
        logic [3:0] mask;
        logic [3:0] others;
        int         w;
        bit         rel;
        if (rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_addr = 0;
        end else if (m_busy == 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_addr = w; m_hold = 1;
            end
        end else begin
            mask   = 4'b0001 << m_owner;
            others = r & ~mask;
            rel    = (r[m_owner] == 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
            if (r[m_owner] && m_hold == MAXH && others != 4'b0000) rel = 1'b1;
`endif
            if (rel) begin
                m_ptr = (m_owner + 1) % 4;
                w     = scan(others, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_addr = w; m_hold = 1;
                end else begin
                    m_busy = 0;
                end
            end else if (m_hold < 15) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] ea;
        logic       ev;
        logic       eo;
        eg = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
        ea = m_addr[1:0];
        ev = (m_busy != 0);
        eo = ev ? din[m_addr] : 1'b0;
        n_cmp++;
        assert (grant === eg) else begin
            n_err++;
            $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
        end
        n_cmp++;
        assert ({address1, address0} === ea) else begin
            n_err++;
            $error("FAIL %s address observed=%b expected=%b", tag, {address1, address0}, ea);
        end
        n_cmp++;
        assert (valid === ev) else begin
            n_err++;
            $error("FAIL %s valid observed=%b expected=%b", tag, valid, ev);
        end
        n_cmp++;
        assert (out === eo) else begin
            n_err++;
            $error("FAIL %s out observed=%b expected=%b", tag, out, eo);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rs, input string tag);
        req   = r;
        reset = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        check(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_addr = 0;
        reset = 1'b1;
        req   = 4'b0000;
        din   = 4'b1010;

        step(4'b0000, 1'b1, "reset0");
        step(4'b0000, 1'b1, "reset1");
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle");

        // Two requesters, hand-off without a bubble, then idle with ptr at 3.
        step(4'b0101, 1'b0, "grant0");
        step(4'b0101, 1'b0, "hold0");
        step(4'b0100, 1'b0, "handoff2");
        step(4'b0000, 1'b0, "release_idle");
        step(4'b1010, 1'b0, "ptr3_pick");
        step(4'b0000, 1'b0, "idle_again");

        // Owner 1 with in1 toggling while the other data inputs are unknown.
        step(4'b0010, 1'b0, "grant1");
        din = 4'bxx0x; #1; check("in1_lo");
        din = 4'bxx1x; #1; check("in1_hi");
        din = 4'bxx0x; #1; check("in1_lo2");
        din = 4'b0101;

        // Full contention: rotation under timeout, otherwise owner 1 holds.
        for (int i = 0; i < 20; i++) step(4'b1111, 1'b0, "contend");

        // Lone requester keeps the grant well past MAX_HOLD.
        for (int i = 0; i < 20; i++) step(4'b1000, 1'b0, "lone3");

        // Reset mid-burst, then resolution restarts from ptr 0.
        step(4'b0000, 1'b0, "drop");
        step(4'b0010, 1'b0, "grant1b");
        step(4'b0010, 1'b0, "hold1b");
        step(4'b0010, 1'b1, "midreset");
        step(4'b0110, 1'b0, "after_reset");
        step(4'b0110, 1'b0, "after_reset2");

        // Random traffic: requests change occasionally so grants persist.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            logic       rs;
            r   = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            rs  = ($urandom_range(0, 63) == 0);
            din = 4'($urandom_range(0, 15));
            step(r, rs, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
